// File: rtl/alu_mc.sv
// Multi-cycle integer ALU for the execute stage: single-cycle base ops plus the
// M extension on an iterative shift-add multiplier and restoring divider.
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [XLEN-1:0] i_in_b,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic            i_alu_en,
  input  logic            i_alu_imm,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_alu_out
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc_p0;
  logic [XLEN-1:0]   opb_p0;
  logic [2:0]        op_p0;
  logic              neg_p0;
  logic [XLEN-1:0]   res_p1;
  logic              vld_p1;

  function automatic logic [XLEN-1:0] negx(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg2x(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] base_result(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [2:0]      f3,
    input logic [6:0]      f7,
    input logic            en,
    input logic            imm
  );
    logic signed [XLEN-1:0] as;
    logic signed [XLEN-1:0] bs;
    logic signed [XLEN-1:0] sra_v;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    as    = a;
    bs    = b;
    sh    = b[SHW-1:0];
    sra_v = as >>> sh;
    case (f3)
      3'b000:  r = (!imm && f7 == 7'h20) ? a - b : a + b;
      3'b001:  r = a << sh;
      3'b010:  r = {{(XLEN-1){1'b0}}, as < bs};
      3'b011:  r = {{(XLEN-1){1'b0}}, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = (f7 == 7'h20) ? sra_v : a >> sh;
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    // Address-calculation mode ignores the operation select entirely.
    if (!en) r = a + b;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] div_special(
    input logic [XLEN-1:0] a,
    input logic            is_rem,
    input logic            by_zero
  );
    logic [XLEN-1:0] r;
    if (by_zero) r = is_rem ? a : {XLEN{1'b1}};
    else         r = is_rem ? {XLEN{1'b0}} : a;
    return r;
  endfunction

  logic            is_m, accept, div_zero, div_ovf, special, m_go;
  logic            a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;

  assign accept   = i_start && !o_busy && !i_flush;
  assign is_m     = i_alu_en && !i_alu_imm && (i_funct7 == 7'h01);
  assign div_zero = (i_in_b == '0);
  assign div_ovf  = !i_funct3[0] && (i_in_a == MOST_NEG) && (i_in_b == '1);
  assign special  = i_funct3[2] && (div_zero || div_ovf);
  assign m_go     = accept && is_m && !special;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (i_funct3)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
    a_neg = a_sgn & i_in_a[XLEN-1];
    b_neg = b_sgn & i_in_b[XLEN-1];
    // Remainder follows the dividend; products and quotients follow the sign product.
    case (i_funct3)
      3'b001, 3'b010, 3'b100: neg_in = a_neg ^ b_neg;
      3'b110:                 neg_in = a_neg;
      default:                neg_in = 1'b0;
    endcase
    a_mag = negx(i_in_a, a_neg);
    b_mag = negx(i_in_b, b_neg);
  end

  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   done_res;

  // Accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    addend    = acc_p0[0] ? opb_p0 : '0;
    mul_sum   = {1'b0, acc_p0[2*XLEN-1:XLEN]} + {1'b0, addend};
    mul_next  = {mul_sum, acc_p0[XLEN-1:1]};
    div_shift = acc_p0[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opb_p0};
    if (div_diff[XLEN]) div_next = {div_shift[XLEN-1:0], acc_p0[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc_p0[XLEN-2:0], 1'b1};
    prod = neg2x(acc_p0, neg_p0);
    if (!op_p0[2]) done_res = (op_p0[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else           done_res = negx(op_p0[1] ? acc_p0[2*XLEN-1:XLEN] : acc_p0[XLEN-1:0], neg_p0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_go) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      vld_p1    <= 1'b0;
      o_alu_out <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_flush) begin
        o_busy <= 1'b0;
        vld_p1 <= 1'b0;
      end else begin
        if (accept) begin
          if (!is_m) begin
            o_alu_out <= base_result(i_in_a, i_in_b, i_funct3, i_funct7, i_alu_en, i_alu_imm);
            o_valid   <= 1'b1;
          end else if (special) begin
            o_alu_out <= div_special(i_in_a, i_funct3[1], div_zero);
            o_valid   <= 1'b1;
          end else begin
            o_busy <= 1'b1;
            cnt    <= CW'(XLEN);
          end
        end
        if (state == CALC) cnt <= cnt - CW'(1);
        vld_p1 <= (state == DONE);
        // Result stage: the M result lands one edge after DONE, releasing busy.
        if (vld_p1) begin
          o_alu_out <= res_p1;
          o_valid   <= 1'b1;
          o_busy    <= 1'b0;
        end
      end
    end
  end

  // Iteration datapath: operand latch at accept, one step per CALC cycle.
  always_ff @(posedge i_clk) begin
    if (m_go && state == IDLE) begin
      acc_p0 <= {{XLEN{1'b0}}, a_mag};
      opb_p0 <= b_mag;
      op_p0  <= i_funct3;
      neg_p0 <= neg_in;
    end else if (state == CALC) begin
      acc_p0 <= op_p0[2] ? div_next : mul_next;
    end
    // Sign-correction/select stage.
    if (state == DONE) res_p1 <= done_res;
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: 32-bit instance for base/M/flush
// scenarios and a 64-bit instance for width-dependent behaviour.
module tb_alu_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, en, imm, start32, start64;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] a32, b32, out32;
  logic [63:0] a64, b64, out64;
  logic        busy32, valid32, busy64, valid64;
  int checks = 0;
  int passed = 0;

  alu_mc #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(start32), .i_flush(flush),
    .i_in_a(a32), .i_in_b(b32), .i_funct3(f3), .i_funct7(f7),
    .i_alu_en(en), .i_alu_imm(imm),
    .o_busy(busy32), .o_valid(valid32), .o_alu_out(out32)
  );

  alu_mc #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_start(start64), .i_flush(flush),
    .i_in_a(a64), .i_in_b(b64), .i_funct3(f3), .i_funct7(f7),
    .i_alu_en(en), .i_alu_imm(imm),
    .o_busy(busy64), .o_valid(valid64), .o_alu_out(out64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fn3,
                       input logic [6:0] fn7, input logic e, input logic im);
    a32 = a; b32 = b; f3 = fn3; f7 = fn7; en = e; imm = im;
  endtask

  // Steps until o_valid (bounded); lat=0 means it never came.
  task automatic wait32(input int maxc, output int lat, output logic [31:0] res, output int busy_low);
    lat = 0; res = '0; busy_low = 0;
    for (int n = 1; n <= maxc; n++) begin
      step();
      if (valid32 === 1'b1) begin
        lat = n;
        res = out32;
        break;
      end
      if (busy32 !== 1'b1) busy_low++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    checks++; if (busy32 !== 1'b0) $display("FAIL reset busy: got %b want 0", busy32); else passed++;
    checks++; if (valid32 !== 1'b0) $display("FAIL reset valid: got %b want 0", valid32); else passed++;
    checks++; if (out32 !== 32'h0) $display("FAIL reset out: got %h want 0", out32); else passed++;
    rst = 1'b0;
    set32(32'd1, 32'd1, 3'd0, 7'h00, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    checks++; if (out32 !== 32'd2) $display("FAIL pre-reset add: got %h want 2", out32); else passed++;
    set32(32'd100, 32'd7, 3'd5, 7'h01, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (busy32 !== 1'b0) $display("FAIL midop reset busy: got %b want 0", busy32); else passed++;
    checks++; if (valid32 !== 1'b0) $display("FAIL midop reset valid: got %b want 0", valid32); else passed++;
    checks++; if (out32 !== 32'h0) $display("FAIL midop reset out: got %h want 0", out32); else passed++;
    set32(32'd3, 32'd4, 3'd0, 7'h00, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    checks++; if (valid32 !== 1'b1) $display("FAIL add after reset valid: got %b want 1", valid32); else passed++;
    checks++; if (out32 !== 32'd7) $display("FAIL add after reset out: got %h want 7", out32); else passed++;
  endtask

  task automatic test_base_ops();
    logic [31:0] va [13] = '{32'd5, 32'h80000000, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd10, 32'd5, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd6, 32'h80000000};
    logic [31:0] vb [13] = '{32'd7, 32'd4, 32'd4, 32'd31, 32'd1, 32'd1,
                             32'd3, 32'd7, 32'hFF00, 32'hFF00, 32'hFF00, 32'd7, 32'd31};
    logic [2:0]  vf3 [13] = '{3'd0, 3'd5, 3'd5, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd4, 3'd6, 3'd7, 3'd0, 3'd5};
    logic [6:0]  vf7 [13] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20,
                              7'h00, 7'h00, 7'h00, 7'h01, 7'h20};
    logic        ven [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        vim [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vexp [13] = '{32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'h80000000, 32'd1, 32'd0,
                               32'd13, 32'd12, 32'h0FF0, 32'hFFF0, 32'hF000, 32'd13, 32'hFFFFFFFF};
    for (int i = 0; i < 13; i++) begin
      set32(va[i], vb[i], vf3[i], vf7[i], ven[i], vim[i]);
      start32 = 1'b1; step(); start32 = 1'b0;
      checks++; if (valid32 !== 1'b1 || busy32 !== 1'b0)
        $display("FAIL base[%0d] handshake: got valid=%b busy=%b want valid=1 busy=0", i, valid32, busy32);
      else passed++;
      checks++; if (out32 !== vexp[i]) $display("FAIL base[%0d] result: got %h want %h", i, out32, vexp[i]);
      else passed++;
    end
    step();
    checks++; if (valid32 !== 1'b0) $display("FAIL base valid strobe: got %b want 0", valid32); else passed++;
  endtask

  task automatic test_mul();
    logic [31:0] ma [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd7};
    logic [31:0] mb [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFA};
    logic [2:0]  mf [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd0};
    logic [31:0] me [6] = '{32'd1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFD6};
    int lat, bl;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      set32(ma[i], mb[i], mf[i], 7'h01, 1'b1, 1'b0);
      start32 = 1'b1; step(); start32 = 1'b0;
      checks++; if (busy32 !== 1'b1) $display("FAIL mul[%0d] busy at accept: got %b want 1", i, busy32); else passed++;
      wait32(80, lat, res, bl);
      checks++; if (lat !== 34) $display("FAIL mul[%0d] latency: got %0d want 34", i, lat); else passed++;
      checks++; if (bl !== 0) $display("FAIL mul[%0d] busy dropped: got %0d low cycles want 0", i, bl); else passed++;
      checks++; if (busy32 !== 1'b0) $display("FAIL mul[%0d] busy at valid: got %b want 0", i, busy32); else passed++;
      checks++; if (res !== me[i]) $display("FAIL mul[%0d] result: got %h want %h", i, res, me[i]); else passed++;
      step();
      checks++; if (valid32 !== 1'b0) $display("FAIL mul[%0d] valid twice: got %b want 0", i, valid32); else passed++;
    end
  endtask

  task automatic test_div();
    logic [31:0] da [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] db [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [2:0]  df [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] de [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
    int lat, bl;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      set32(da[i], db[i], df[i], 7'h01, 1'b1, 1'b0);
      start32 = 1'b1; step(); start32 = 1'b0;
      wait32(80, lat, res, bl);
      checks++; if (lat !== 34) $display("FAIL div[%0d] latency: got %0d want 34", i, lat); else passed++;
      checks++; if (res !== de[i]) $display("FAIL div[%0d] result: got %h want %h", i, res, de[i]); else passed++;
    end
  endtask

  task automatic test_div_special();
    logic [31:0] sa [6] = '{32'd123, 32'd9, 32'h80000000, 32'h80000000, 32'd5, 32'd77};
    logic [31:0] sb [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [2:0]  sf [6] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] se [6] = '{32'hFFFFFFFF, 32'd9, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd77};
    for (int i = 0; i < 6; i++) begin
      set32(sa[i], sb[i], sf[i], 7'h01, 1'b1, 1'b0);
      start32 = 1'b1; step(); start32 = 1'b0;
      checks++; if (valid32 !== 1'b1 || busy32 !== 1'b0)
        $display("FAIL divspec[%0d] handshake: got valid=%b busy=%b want valid=1 busy=0", i, valid32, busy32);
      else passed++;
      checks++; if (out32 !== se[i]) $display("FAIL divspec[%0d] result: got %h want %h", i, out32, se[i]); else passed++;
      step();
      checks++; if (valid32 !== 1'b0 || busy32 !== 1'b0)
        $display("FAIL divspec[%0d] after: got valid=%b busy=%b want 0 0", i, valid32, busy32);
      else passed++;
    end
  endtask

  task automatic test_flush();
    int nvalid;
    set32(32'd1, 32'd2, 3'd0, 7'h00, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    set32(32'd100, 32'd7, 3'd5, 7'h01, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (busy32 !== 1'b0 || valid32 !== 1'b0)
      $display("FAIL flush state: got busy=%b valid=%b want 0 0", busy32, valid32);
    else passed++;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid32 === 1'b1) nvalid++;
    end
    checks++; if (nvalid !== 0) $display("FAIL flush no result: got %0d valids want 0", nvalid); else passed++;
    checks++; if (out32 !== 32'd3) $display("FAIL flush holds out: got %h want 3", out32); else passed++;
    set32(32'd5, 32'd5, 3'd0, 7'h00, 1'b1, 1'b0);
    start32 = 1'b1; flush = 1'b1; step(); start32 = 1'b0; flush = 1'b0;
    checks++; if (valid32 !== 1'b0 || out32 !== 32'd3)
      $display("FAIL flush beats start: got valid=%b out=%h want 0 3", valid32, out32);
    else passed++;
    set32(32'd8, 32'd8, 3'd0, 7'h00, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    flush = 1'b1; #1;
    checks++; if (valid32 !== 1'b1 || out32 !== 32'd16)
      $display("FAIL flush keeps valid: got valid=%b out=%h want 1 10", valid32, out32);
    else passed++;
    step(); flush = 1'b0;
    checks++; if (valid32 !== 1'b0 || out32 !== 32'd16)
      $display("FAIL flush after base: got valid=%b out=%h want 0 10", valid32, out32);
    else passed++;
  endtask

  task automatic test_contention();
    int lat, bl, nvalid;
    logic [31:0] res;
    set32(32'd100, 32'd7, 3'd5, 7'h01, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    set32(32'd3, 32'd3, 3'd0, 7'h01, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    wait32(80, lat, res, bl);
    checks++; if (lat !== 29) $display("FAIL busy start latency: got %0d want 29", lat); else passed++;
    checks++; if (res !== 32'd14) $display("FAIL busy start result: got %h want e", res); else passed++;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid32 === 1'b1) nvalid++;
    end
    checks++; if (nvalid !== 0) $display("FAIL busy start queued: got %0d valids want 0", nvalid); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bl;
    logic [31:0] res;
    set32(32'd1, 32'd1, 3'd0, 7'h00, 1'b1, 1'b0); start32 = 1'b1; step();
    checks++; if (valid32 !== 1'b1 || out32 !== 32'd2) $display("FAIL b2b op0: got valid=%b out=%h want 1 2", valid32, out32); else passed++;
    set32(32'hFF, 32'h0F, 3'd4, 7'h00, 1'b1, 1'b0); step();
    checks++; if (valid32 !== 1'b1 || out32 !== 32'hF0) $display("FAIL b2b op1: got valid=%b out=%h want 1 f0", valid32, out32); else passed++;
    set32(32'hFF, 32'h3C, 3'd7, 7'h00, 1'b1, 1'b0); step();
    checks++; if (valid32 !== 1'b1 || out32 !== 32'h3C) $display("FAIL b2b op2: got valid=%b out=%h want 1 3c", valid32, out32); else passed++;
    set32(32'd100, 32'd7, 3'd5, 7'h01, 1'b1, 1'b0); step(); start32 = 1'b0;
    checks++; if (busy32 !== 1'b1) $display("FAIL b2b m accept: got busy=%b want 1", busy32); else passed++;
    wait32(80, lat, res, bl);
    checks++; if (lat !== 34 || res !== 32'd14) $display("FAIL b2b divu: got lat=%0d out=%h want 34 e", lat, res); else passed++;
    set32(32'd6, 32'd7, 3'd0, 7'h01, 1'b1, 1'b0); start32 = 1'b1; step(); start32 = 1'b0;
    checks++; if (busy32 !== 1'b1) $display("FAIL b2b start in valid cycle: got busy=%b want 1", busy32); else passed++;
    wait32(80, lat, res, bl);
    checks++; if (lat !== 34 || res !== 32'd42) $display("FAIL b2b mul: got lat=%0d out=%h want 34 2a", lat, res); else passed++;
  endtask

  task automatic test_width64();
    int lat;
    logic [63:0] res;
    a64 = '1; b64 = '1; f3 = 3'd3; f7 = 7'h01; en = 1'b1; imm = 1'b0;
    start64 = 1'b1; step(); start64 = 1'b0;
    lat = 0; res = '0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (valid64 === 1'b1) begin
        lat = n;
        res = out64;
        break;
      end
    end
    checks++; if (lat !== 66) $display("FAIL mulhu64 latency: got %0d want 66", lat); else passed++;
    checks++; if (res !== 64'hFFFFFFFFFFFFFFFE) $display("FAIL mulhu64 result: got %h want fffffffffffffffe", res); else passed++;
    a64 = 64'h8000000000000000; b64 = 64'd63; f3 = 3'd5; f7 = 7'h20; en = 1'b1; imm = 1'b1;
    start64 = 1'b1; step(); start64 = 1'b0;
    checks++; if (valid64 !== 1'b1 || out64 !== 64'hFFFFFFFFFFFFFFFF)
      $display("FAIL sra64: got valid=%b out=%h want 1 ffffffffffffffff", valid64, out64);
    else passed++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; start32 = 1'b0; start64 = 1'b0;
    en = 1'b1; imm = 1'b0; f3 = 3'd0; f7 = 7'h00;
    a32 = '0; b32 = '0; a64 = '0; b64 = '0;
    test_reset();
    test_base_ops();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_contention();
    test_back_to_back();
    test_width64();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the RISK CPU execute stage.
- Adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) to the base integer ALU.
- Operand width is configurable.
- Base operations complete in one registered cycle. M operations run on an iterative shift-add multiplier or a restoring divider, with a start/busy/valid handshake towards the pipeline stall logic.

## Interface
Parameters:
- XLEN, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  request; accepted on an edge where i_start=1, o_busy=0, i_flush=0
- i_flush  in  1  abort in-flight operation; no result produced
- i_in_a  in  XLEN  operand A
- i_in_b  in  XLEN  operand B (register or immediate)
- i_funct3  in  3  operation select
- i_funct7  in  7  operation modifier
- i_alu_en  in  1  0: force A+B (address calculation)
- i_alu_imm  in  1  1: I-type; disables SUB and M decode
- o_busy  out  1  M operation in progress
- o_valid  out  1  one-cycle result strobe
- o_alu_out  out  XLEN  registered result, held until next o_valid

## Operation
Decode is applied at acceptance only. Operand inputs are don't-care afterwards.

Base operation decode (registered result):
- Base op: i_alu_en=0, or i_alu_imm=1, or i_funct7≠7'h01.
- i_alu_en=0: result is A+B.
- SUB: funct3=000, !imm, funct7=7'h20.
- SLL/SRL/SRA use B[SHW-1:0]. SRA when funct7=7'h20, for both immediate and register forms.
- SLT/SLTU are signed/unsigned compares, zero-extended to XLEN.
- XOR/OR/AND are bitwise.

M operation decode:
- M op: i_alu_en=1, !imm, funct7=7'h01.
- funct3 000..111 map to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

State machine IDLE → CALC → DONE → IDLE:
- IDLE: on accepting an M op, latch the operand magnitudes (signed operands negated if negative) and the result-sign flag. Load counter = XLEN and go to CALC.
- IDLE, divide special cases skip CALC:
  - Divide by zero: quotient all ones, remainder = A.
  - Signed overflow (A = most-negative, B = −1): quotient = A, remainder 0.
  - Both go directly to the result register, same latency as a base op, with o_busy never asserted.
- CALC: one iteration per cycle.
  - Multiplier: 2·XLEN accumulator, shift-add.
  - Divider: restoring shift-subtract.
  - Counter decrements; on the iteration where counter=1, go to DONE.
- DONE: apply sign correction (negate if flag set) and select the result. MUL takes the low half; MULH/MULHSU/MULHU take the high half. Register o_alu_out, pulse o_valid, go to IDLE.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - DIV quotient is negative iff operand signs differ.
  - REM takes the sign of the dividend.
- All arithmetic is modulo 2^XLEN. There are no exceptions or flags.

## Timing
- Reset values: o_busy=0, o_valid=0, o_alu_out=0, state=IDLE, counter=0.
- Base op and divide special case: o_valid=1 in the cycle after the accepting edge (latency 1). Accepted back-to-back every cycle.
- M op: o_busy=1 from the accepting edge. o_valid=1 exactly XLEN+2 edges after the accepting edge, and o_busy=0 in that same cycle. A new i_start is accepted in the o_valid cycle.
- i_start while o_busy=1: ignored; no queuing.
- i_flush:
  - Next edge: state=IDLE, o_busy=0, o_valid=0.
  - o_alu_out keeps its previous value.
  - i_flush and i_start on the same edge: flush wins and the request is dropped.
  - i_flush during a base-op result cycle does not retract an o_valid already asserted.
- i_rst mid-operation: identical to i_flush, and also clears o_alu_out to 0. i_rst overrides all other inputs.
- o_valid is never high for two consecutive cycles from a single request.

## Test plan
- Reset:
  - Assert i_rst during a DIVU: o_busy=0, o_valid=0, o_alu_out=0 next cycle.
  - Then ADD 3+4 → 7 after 1 edge.
- Base ops (XLEN=32), each valid 1 edge after accept:
  - SUB 5−7 → 0xFFFFFFFE.
  - SRA 0x80000000>>4 → 0xF8000000.
  - SRL 0x80000000>>4 → 0x08000000.
  - SLLI 1<<31 → 0x80000000.
  - SLT −1<1 → 1; SLTU → 0.
  - i_alu_en=0 with funct7=0x20 → A+B.
- Multiply, A=B=0xFFFFFFFF:
  - MUL → 1, MULH → 0, MULHU → 0xFFFFFFFE, MULHSU → 0xFFFFFFFF.
  - Each has o_valid exactly 34 edges after accept, and o_busy high for edges 1..33.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
  - DIV x/0 → 0xFFFFFFFF at latency 1, o_busy never high.
  - REM 9/0 → 9.
  - DIV 0x80000000/−1 → 0x80000000; REM → 0.
- Flush and contention:
  - i_flush on CALC cycle 10 of a DIVU: no o_valid, o_busy=0 next cycle.
  - i_start during busy: ignored, and the result belongs to the original request.
  - Back-to-back start in the o_valid cycle: accepted.
- Width (XLEN=64 build):
  - MULHU of all-ones → 0xFFFFFFFFFFFFFFFE at latency 66.
  - SRA by 63 of the most-negative value → all ones.
